// File: rtl/uart_receive.sv
// ============================================================================
// uart_receive
// ----------------------------------------------------------------------------
// 8N1 UART receiver, LSB first, fixed baud set by CLKS_PER_BIT. Runs in the
// CPU clock domain: RxD is brought in through a two-flop synchronizer, the
// start bit is re-checked at mid-bit, every data bit and the stop bit are
// sampled at mid-bit, and the received byte is handed to the consumer through
// a dataValid / readAck handshake.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (must be >= 4)
//   HALF_BIT      cycles from start-edge detection to the start-bit check
//
// Ports
//   clk           CPU clock, rising edge
//   reset         asynchronous, active-high reset
//   rxd           UART RxD pin (asynchronous, idles high)
//   readAck       one-cycle pulse: clears dataValid, framingError, overrun
//   dataOutput    last received byte
//   dataValid     high while an unconsumed byte is held
//   framingError  sticky: a stop bit was sampled low
//   overrun       sticky: a byte arrived while the previous one was unread
//   busy          high in any state other than IDLE
// ============================================================================
module uart_receive #(
    parameter int unsigned CLKS_PER_BIT = 435,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       readAck,
    output logic [7:0] dataOutput,
    output logic       dataValid,
    output logic       framingError,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic        sync1;
    logic        rxd_s;
    logic [15:0] counter;
    logic [2:0]  bit_index;
    logic [7:0]  shift;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            counter      <= '0;
            bit_index    <= '0;
            shift        <= '0;
            dataOutput   <= '0;
            dataValid    <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // The ack clear is written first so that any flag set later in the
            // same cycle (new byte, framing error, overrun) takes priority.
            if (readAck) begin
                dataValid    <= 1'b0;
                framingError <= 1'b0;
                overrun      <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        counter <= '0;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        if (!rxd_s) begin
                            state     <= DATA;
                            bit_index <= '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter           <= '0;
                        shift[bit_index]  <= rxd_s;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        if (rxd_s) begin
                            dataOutput <= shift;
                            dataValid  <= 1'b1;
                            if (dataValid && !readAck) begin
                                overrun <= 1'b1;
                            end
                            // Back to IDLE at mid stop bit so a following
                            // start edge needs no gap.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            framingError <= 1'b1;
                            state        <= WAIT_IDLE;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not
                    // decoded as a stream of start bits.
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_receive.md
# uart_receive

UART receiver, 8N1 format, LSB first, fixed baud set by a clock-cycles-per-bit parameter. It is the receive-side counterpart of the existing UART transmitter and runs in the CPU clock domain. It synchronizes the asynchronous RxD pin, validates the start bit, samples each bit at mid-bit and delivers bytes through a valid/acknowledge handshake. It flags framing errors and overruns to the CPU.

## Interface
- CLKS_PER_BIT, 435: clock cycles per bit period. Must be at least 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide): cycles from the start-edge detection to the start-bit check.
- clk  input  1  CPU clock, rising edge.
- reset  input  1  Asynchronous, active-high. Forces every register to its reset value immediately.
- rxd  input  1  UART RxD pin, asynchronous. Idles high.
- readAck  input  1  One-cycle pulse from the consumer. Clears dataValid, framingError and overrun.
- dataOutput  output  8  Last received byte. Reset value 0.
- dataValid  output  1  High while an unconsumed byte is held. Reset value 0.
- framingError  output  1  Sticky flag: a stop bit was sampled low. Reset value 0.
- overrun  output  1  Sticky flag: a byte arrived while dataValid was high with no ack. Reset value 0.
- busy  output  1  High in any state except IDLE. Reset value 0.

## Operation
- Synchronizer: two flops, rxd to sync1 to rxdS. Both reset to 1. Only rxdS is used by the logic.
- Registers:
  - state (IDLE, START, DATA, STOP, WAIT_IDLE)
  - counter, 16 bits
  - bitIndex, 3 bits
  - shift, 8 bits
- Every counter compare uses ==. Counters reset to 0 on each state transition.
- IDLE: if rxdS==0, go to START with counter=0. Otherwise hold.
- START: counter increments each cycle. When counter==HALF_BIT-1:
  - rxdS==0: go to DATA with counter=0 and bitIndex=0.
  - rxdS==1: treat as a glitch and return to IDLE. No flags change.
- DATA: when counter==CLKS_PER_BIT-1:
  - shift[bitIndex] <= rxdS, counter <= 0.
  - If bitIndex==7, go to STOP. Otherwise bitIndex increments.
- STOP: when counter==CLKS_PER_BIT-1:
  - rxdS==1: dataOutput <= shift, dataValid <= 1. Set overrun if dataValid==1 and readAck==0 in the same cycle. Go to IDLE.
  - rxdS==0: framingError <= 1, dataValid is unchanged, dataOutput is unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rxdS==1, then go to IDLE. This prevents a break or stuck-low line from being read as repeated start bits.
- readAck clears dataValid, framingError and overrun on the next edge, in any state. A readAck while dataValid==0 only clears the flags.
- Simultaneous delivery and readAck: the new byte wins. dataValid stays 1, overrun is not set, and overrun/framingError are cleared.
- Simultaneous framing error and readAck: framingError ends at 1. The flag set takes priority over the ack clear.
- busy = (state != IDLE), registered alongside state.

## Timing
- rxd to rxdS: 2 cycles.
- Let T0 be the edge at which IDLE sees rxdS==0.
- Start-bit check at edge T0+HALF_BIT.
- Data bit i (i = 0..7) sampled at edge T0+HALF_BIT+(i+1)*CLKS_PER_BIT.
- Stop bit sampled at edge T0+HALF_BIT+9*CLKS_PER_BIT. dataValid is high after this edge.
- End to end: dataValid rises 2+HALF_BIT+9*CLKS_PER_BIT cycles after the rxd falling edge is first captured by sync1.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge is accepted with no gap required. Tolerates about ±4% baud mismatch.
- Reset mid-frame: all outputs and state return to reset values at once. After release, the remainder of the interrupted frame is ignored only if the line is high. If the line is low, the receiver resynchronizes on the next low it sees.
- Consumer latency is unbounded. Held data is never overwritten silently; every overwrite sets overrun.

## Test plan
Use CLKS_PER_BIT=16, HALF_BIT=8 in all scenarios.
- Single byte: drive 8N1 frame 0xA5 at 16 cycles/bit → dataValid rises exactly 2+8+144 cycles after the first sync1 capture of the falling edge; dataOutput=0xA5; no flags; busy high for 8+144 cycles.
- Glitch: low pulse of 5 cycles on idle line → state returns to IDLE at the start check; dataValid, framingError and overrun all stay 0.
- Framing error: frame 0x3C with stop bit held low for 2 bit times, then high → framingError=1, dataValid=0, busy stays high until rxdS goes high; a following good frame 0x11 is received correctly.
- Overrun: two back-to-back frames 0x01 then 0x02 with no readAck → dataOutput=0x02, dataValid=1, overrun=1; readAck pulse → all three flags cleared next cycle.
- Ack collision: readAck asserted exactly on the stop-sample edge of a second frame 0x7E → dataValid=1, dataOutput=0x7E, overrun=0.
- Async reset mid-frame: assert reset during data bit 4 of 0xFF → all outputs 0 and busy=0 with no clock edge; after release with the line high, the next frame 0x5A is received correctly.
